inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer-side companion to the instruction memory. Receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and issues single-cycle word writes to the instruction memory write port.
- Holds the CPU off (busy) while loading. Addresses are word-aligned byte addresses: word index sits at addr[ADDR_WIDTH+1:2].

Parameters:
- ADDR_WIDTH, 8, log2 of instruction memory depth in words; maximum image is 2**ADDR_WIDTH words.
- BYTE_ORDER, 0, 0 = first byte of each word goes to [31:24] (big-endian); 1 = first byte goes to [7:0].

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready at posedge.
- mem_addr  out  32  write byte address, {word_idx, 2'b00}, upper bits zero.
- mem_wdata  out  32  assembled instruction word.
- mem_we  out  1  one-cycle write strobe.
- busy  out  1  high in LEN_HI, LEN_LO, DATA; CPU is held while high.
- done  out  1  sticky; load completed successfully.
- error  out  1  sticky; header length exceeded capacity.
- words_written  out  16  count of words committed in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rx_ready, mem_we, busy, done and error all 0; mem_addr, mem_wdata and words_written all 0; byte counter, length and assembly register cleared. Applies immediately, including mid-load. A partial word is discarded and no write is issued.
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR. All outputs are registered except rx_ready and busy, which decode from the state.
- IDLE/DONE/ERR with start=1 → LEN_HI. On that edge: done, error and words_written clear, and the byte counter and word index clear.
- start in LEN_HI, LEN_LO or DATA is ignored.
- rx_ready=1 in LEN_HI, LEN_LO and DATA; 0 otherwise.
- LEN_HI: accepted byte → len[15:8], go to LEN_LO.
- LEN_LO: accepted byte → len[7:0]. Then:
  - {len_hi, byte} == 0 → DONE, done=1, no writes.
  - {len_hi, byte} > 2**ADDR_WIDTH → ERR, error=1.
  - otherwise → DATA.
- DATA:
  - 2-bit byte counter 0..3. Byte k is placed in lane 3-k when BYTE_ORDER=0, or lane k when BYTE_ORDER=1.
  - When the 4th byte is accepted at edge t, the following appear in the cycle after t (one-cycle latency), with mem_we high for exactly one cycle:
    - mem_we=1;
    - mem_wdata = full word, including the 4th byte;
    - mem_addr = word_idx*4;
    - words_written increments.
  - word_idx then increments.
  - rx_ready stays 1 through the write cycle, so back-to-back bytes at full rate are supported: one word per 4 cycles.
  - When the last word's 4th byte is accepted → DONE. done=1 is asserted in the same cycle as that final mem_we.
- word_idx range is 0..2**ADDR_WIDTH-1. A load of exactly 2**ADDR_WIDTH words is legal, and the last address is (2**ADDR_WIDTH-1)*4. word_idx never wraps within a load.
- rx_valid while rx_ready=0: no transfer, no state change; the byte is not consumed.
- mem_wdata and mem_addr hold their last values when mem_we=0.
- ERR and DONE are terminal until start or reset. busy=0 in both.

Test Plan:
- Reset then start; stream 00 02 DE AD BE EF 00 00 00 0C (BYTE_ORDER=0) → mem_we pulses with (addr 0x0, data 0xDEADBEEF) then (addr 0x4, data 0x0000000C); done=1 with the 2nd write; words_written=2; busy falls to 0.
- BYTE_ORDER=1, start, stream 00 01 11 22 33 44 → single write addr 0x0, data 0x44332211; done=1.
- start, length bytes 01 01 (257 > 256) → error=1, rx_ready=0, no mem_we, busy=0; a further start re-arms with error cleared.
- start, length 00 00 → done=1 immediately after the 2nd byte; zero writes.
- rx_valid toggled randomly, plus start pulses mid-load with length 00 03 → writes occur only on the 4th accepted byte of each word; start is ignored; words at addrs 0x0, 0x4, 0x8.
- Assert reset after 6 data bytes of a 3-word load → mem_we never asserts for the partial 2nd word; all outputs 0 immediately; after release and start, the new load begins at addr 0x0.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, packs bytes into
// 32-bit words and issues single-cycle word writes while holding the CPU off via busy.
module inst_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_ORDER = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StDone,
        StErr
    } state_e;

    // Capacity in words; 17 bits so a full 16-bit header can be compared against it.
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           words_written_q, words_written_d;

    logic                  xfer;
    logic [15:0]           len_full;
    logic [1:0]            lane;

    // Handshake and busy decode straight from the state.
    always_comb begin
        rx_ready = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
        busy     = rx_ready;
    end

    // Next-state logic: header parse, byte packing and word commit.
    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        byte_cnt_d      = byte_cnt_q;
        word_idx_d      = word_idx_q;
        asm_d           = asm_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_we_d        = 1'b0;
        done_d          = done_q;
        error_d         = error_q;
        words_written_d = words_written_q;

        xfer     = rx_valid & rx_ready;
        len_full = {len_q[15:8], rx_data};
        lane     = (BYTE_ORDER == 1) ? byte_cnt_q : (2'd3 - byte_cnt_q);

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d         = StLenHi;
                    done_d          = 1'b0;
                    error_d         = 1'b0;
                    words_written_d = '0;
                    byte_cnt_d      = '0;
                    word_idx_d      = '0;
                    len_d           = '0;
                    asm_d           = '0;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    if (len_full == 16'd0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if ({1'b0, len_full} > MaxWords) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    asm_d[{lane, 3'b000} +: 8] = rx_data;
                    byte_cnt_d                 = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d        = 1'b1;
                        mem_wdata_d     = asm_d;
                        mem_addr_d      = 32'({word_idx_q, 2'b00});
                        words_written_d = words_written_q + 16'd1;
                        if (words_written_q + 16'd1 == len_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            // Held at the last index on the final word so it never wraps.
                            word_idx_d = word_idx_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            len_q           <= '0;
            byte_cnt_q      <= '0;
            word_idx_q      <= '0;
            asm_q           <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            byte_cnt_q      <= byte_cnt_d;
            word_idx_q      <= word_idx_d;
            asm_q           <= asm_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            done_q          <= done_d;
            error_q         <= error_d;
            words_written_q <= words_written_d;
        end
    end

    // Registered outputs.
    always_comb begin
        mem_addr      = mem_addr_q;
        mem_wdata     = mem_wdata_q;
        mem_we        = mem_we_q;
        done          = done_q;
        error         = error_q;
        words_written = words_written_q;
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: two instances (big- and little-endian packing) share one stream;
// a stream-level model predicts every output each cycle, plus literal pins per scenario.
module tb_inst_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;

    logic        rx_ready0, mem_we0, busy0, done0, error0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [15:0] words_written0;
    logic        rx_ready1, mem_we1, busy1, done1, error1;
    logic [31:0] mem_addr1, mem_wdata1;
    logic [15:0] words_written1;

    inst_loader #(.ADDR_WIDTH(AW), .BYTE_ORDER(0)) u_be (
        .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
        .busy(busy0), .done(done0), .error(error0), .words_written(words_written0)
    );

    inst_loader #(.ADDR_WIDTH(AW), .BYTE_ORDER(1)) u_le (
        .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
        .busy(busy1), .done(done1), .error(error1), .words_written(words_written1)
    );

    always #5 clock = ~clock;

    // Stream-level model of what the outputs must show after each edge.
    bit          m_loading;
    int          m_hdr;
    int          m_len;
    logic [7:0]  m_buf[$];
    int          m_words;
    bit          m_done, m_err, m_we;
    logic [31:0] m_addr, m_wdata_be, m_wdata_le;

    int checks = 0;
    int failures = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_be[$];
    logic [31:0] obs_le[$];
    bit          obs_done[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_hdr = 0; m_len = 0; m_words = 0;
        m_done = 0; m_err = 0; m_we = 0;
        m_addr = '0; m_wdata_be = '0; m_wdata_le = '0;
        m_buf.delete();
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit s, output bit acc);
        acc  = 0;
        m_we = 0;
        if (!m_loading) begin
            if (s) begin
                m_loading = 1; m_hdr = 0; m_words = 0; m_done = 0; m_err = 0;
                m_buf.delete();
            end
        end else if (v) begin
            acc = 1;
            if (m_hdr == 0) begin
                m_len = int'(d) * 256;
                m_hdr = 1;
            end else if (m_hdr == 1) begin
                m_len = m_len + int'(d);
                m_hdr = 2;
                if (m_len == 0) begin
                    m_loading = 0; m_done = 1;
                end else if (m_len > DEPTH) begin
                    m_loading = 0; m_err = 1;
                end
            end else begin
                m_buf.push_back(d);
                if (m_buf.size() == 4) begin
                    m_we       = 1;
                    m_addr     = 32'(m_words * 4);
                    m_wdata_be = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                    m_wdata_le = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                    m_words++;
                    m_buf.delete();
                    if (m_words == m_len) begin
                        m_loading = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("be_rx_ready", 32'(rx_ready0), 32'(m_loading));
        chk("be_busy", 32'(busy0), 32'(m_loading));
        chk("be_mem_we", 32'(mem_we0), 32'(m_we));
        chk("be_mem_addr", mem_addr0, m_addr);
        chk("be_mem_wdata", mem_wdata0, m_wdata_be);
        chk("be_done", 32'(done0), 32'(m_done));
        chk("be_error", 32'(error0), 32'(m_err));
        chk("be_words_written", 32'(words_written0), 32'(m_words));
        chk("le_rx_ready", 32'(rx_ready1), 32'(m_loading));
        chk("le_mem_we", 32'(mem_we1), 32'(m_we));
        chk("le_mem_addr", mem_addr1, m_addr);
        chk("le_mem_wdata", mem_wdata1, m_wdata_le);
        chk("le_done", 32'(done1), 32'(m_done));
        chk("le_error", 32'(error1), 32'(m_err));
        chk("le_words_written", 32'(words_written1), 32'(m_words));
        if (mem_we0) begin
            obs_addr.push_back(mem_addr0);
            obs_be.push_back(mem_wdata0);
            obs_le.push_back(mem_wdata1);
            obs_done.push_back(done0);
        end
    endtask

    // One clock: drive, compare on the falling edge, advance the model, cross the edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit s, output bit acc);
        rx_valid = v;
        rx_data  = d;
        start    = s;
        @(negedge clock);
        check_outputs();
        model_step(v, d, s, acc);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, acc);
    endtask

    task automatic arm();
        bit acc;
        cycle(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic send(input logic [7:0] bytes[$], input bit rnd, input bit rnd_start);
        for (int i = 0; i < bytes.size(); i++) begin
            bit acc;
            int tries;
            acc   = 0;
            tries = 0;
            while (!acc) begin
                bit v;
                bit s;
                v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                s = rnd_start ? ($urandom_range(0, 3) == 0) : 1'b0;
                cycle(v, bytes[i], s, acc);
                tries++;
                if (!acc && tries > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout actual=%0d required=accepted byte %0d", tries, i);
                    return;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_be.delete(); obs_le.delete(); obs_done.delete();
    endtask

    initial begin
        logic [7:0] q[$];
        bit acc;

        model_reset();
        @(posedge clock);
        #1;
        idle(2);
        reset = 1'b1;
        idle(1);

        // Two-word big-endian load.
        clear_obs();
        arm();
        q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h0C};
        send(q, 1'b0, 1'b0);
        idle(2);
        chk("t1_nwrites", 32'(obs_addr.size()), 32'd2);
        chk("t1_data0", obs_be[0], 32'hDEADBEEF);
        chk("t1_addr0", obs_addr[0], 32'h0);
        chk("t1_addr1", obs_addr[1], 32'h4);
        chk("t1_data1", obs_be[1], 32'h0000000C);
        chk("t1_done_with_last", 32'(obs_done[1]), 32'd1);
        chk("t1_words_written", 32'(words_written0), 32'd2);
        chk("t1_busy", 32'(busy0), 32'd0);

        // Single word, little-endian instance pinned.
        clear_obs();
        arm();
        q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send(q, 1'b0, 1'b0);
        idle(2);
        chk("t2_le_data", obs_le[0], 32'h44332211);
        chk("t2_be_data", obs_be[0], 32'h11223344);
        chk("t2_addr", obs_addr[0], 32'h0);
        chk("t2_done", 32'(done1), 32'd1);

        // Oversized header, then bytes offered while not ready.
        clear_obs();
        arm();
        q = '{8'h01, 8'h01};
        send(q, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hAA, 1'b0, acc);
        chk("t3_error", 32'(error0), 32'd1);
        chk("t3_rx_ready", 32'(rx_ready0), 32'd0);
        chk("t3_busy", 32'(busy0), 32'd0);
        chk("t3_nwrites", 32'(obs_addr.size()), 32'd0);
        arm();
        idle(1);
        chk("t3_rearm_error", 32'(error0), 32'd0);
        chk("t3_rearm_busy", 32'(busy0), 32'd1);

        // Zero-length header on the re-armed load.
        q = '{8'h00, 8'h00};
        send(q, 1'b0, 1'b0);
        idle(1);
        chk("t4_done", 32'(done0), 32'd1);
        chk("t4_nwrites", 32'(obs_addr.size()), 32'd0);
        chk("t4_words_written", 32'(words_written0), 32'd0);

        // Throttled stream with stray start pulses.
        clear_obs();
        arm();
        q = '{8'h00, 8'h03};
        for (int i = 0; i < 12; i++) q.push_back(8'(8'h30 + i));
        send(q, 1'b1, 1'b1);
        idle(2);
        chk("t5_nwrites", 32'(obs_addr.size()), 32'd3);
        chk("t5_addr0", obs_addr[0], 32'h0);
        chk("t5_addr1", obs_addr[1], 32'h4);
        chk("t5_addr2", obs_addr[2], 32'h8);
        chk("t5_data2", obs_be[2], 32'h38393A3B);

        // Asynchronous reset in the middle of the second word.
        clear_obs();
        arm();
        q = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send(q, 1'b0, 1'b0);
        rx_valid = 1'b0;
        reset    = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("t6_busy_in_reset", 32'(busy0), 32'd0);
        chk("t6_addr_in_reset", mem_addr0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(2);
        chk("t6_writes_before_reset", 32'(obs_addr.size()), 32'd1);
        clear_obs();
        arm();
        q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send(q, 1'b0, 1'b0);
        idle(2);
        chk("t6_restart_addr", obs_addr[0], 32'h0);
        chk("t6_restart_data", obs_be[0], 32'h01020304);

        // Full-capacity load: 256 words.
        clear_obs();
        arm();
        q = '{8'h01, 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'(i) ^ 8'h5A);
        send(q, 1'b0, 1'b0);
        idle(2);
        chk("t7_nwrites", 32'(obs_addr.size()), 32'(DEPTH));
        chk("t7_last_addr", obs_addr[DEPTH-1], 32'h3FC);
        chk("t7_done", 32'(done0), 32'd1);
        chk("t7_error", 32'(error0), 32'd0);
        chk("t7_words_written", 32'(words_written0), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
